bit_serial_subtractor: RTL and testbench

- Sequential subtractor: computes A − B one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- Companion to the parallel full-adder and carry-skip datapath. This block is the inverse (subtract) operation at minimum area, for multi-cycle, area-constrained paths.
- Start/busy/done handshake; result and final borrow are held until the next operation.

---
 rtl/bit_serial_subtractor_if.sv | 22 ++
 rtl/bit_serial_subtractor.sv | 98 +++++++++
 tb/tb_bit_serial_subtractor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bit_serial_subtractor_if.sv
// Start/busy/done handshake bundle for bit_serial_subtractor.
// The ovf signal exists only when BIT_SERIAL_SUB_OVF_EN is defined.
interface bit_serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef BIT_SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (output start, a, b, input busy, done, diff, borrow, ovf);
   modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
   modport master (output start, a, b, input busy, done, diff, borrow);
   modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/bit_serial_subtractor.sv
// Area-minimal A-B, one bit per clock LSB first, through one full-subtractor cell.
// Optional signed-overflow output enabled by defining BIT_SERIAL_SUB_OVF_EN.
module bit_serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   bit_serial_subtractor_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, diff_q;
   logic [CW-1:0]    cnt;
   logic             bflop, borrow_q, busy_q, done_q;
   logic             ai, bi, d, bout, last;
   logic [WIDTH-1:0] res_next;

   assign ai       = a_sh[0];
   assign bi       = b_sh[0];
   assign d        = ai ^ bi ^ bflop;
   assign bout     = (~ai & bi) | (~(ai ^ bi) & bflop);
   assign res_next = {d, res_sh[WIDTH-1:1]};
   assign last     = (cnt == CW'(WIDTH - 1));

`ifdef BIT_SERIAL_SUB_OVF_EN
   // Operand signs are kept apart because the shift registers lose them.
   logic a_sgn, b_sgn, ovf_q;
   assign bus.ovf = ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         diff_q   <= '0;
         cnt      <= '0;
         bflop    <= 1'b0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef BIT_SERIAL_SUB_OVF_EN
         a_sgn    <= 1'b0;
         b_sgn    <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  a_sh   <= bus.a;
                  b_sh   <= bus.b;
                  res_sh <= '0;
                  bflop  <= 1'b0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
`ifdef BIT_SERIAL_SUB_OVF_EN
                  a_sgn  <= bus.a[WIDTH-1];
                  b_sgn  <= bus.b[WIDTH-1];
`endif
               end else begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_next;
               bflop  <= bout;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  diff_q   <= res_next;
                  borrow_q <= bout;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= DONE;
`ifdef BIT_SERIAL_SUB_OVF_EN
                  ovf_q    <= (a_sgn ^ b_sgn) & (a_sgn ^ d);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed bench: WIDTH=8 instance for the main vectors, WIDTH=2 instance for the exhaustive sweep.
module tb_bit_serial_subtractor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ncmp = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   bit_serial_subtractor_if #(.WIDTH(8)) ifc8 ();
   bit_serial_subtractor_if #(.WIDTH(2)) ifc2 ();

   bit_serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(ifc8.slave));
   bit_serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept one op, check busy across the run and diff holding, then the done cycle.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] prev,
                       input logic [7:0] ed, input logic eb, input string tag);
      ifc8.a = a; ifc8.b = b; ifc8.start = 1'b1;
      tick();
      ifc8.start = 1'b0; ifc8.a = 8'hxx; ifc8.b = 8'hxx;
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_busy"}, ifc8.busy, 1);
         chk({tag, "_nodone"}, ifc8.done, 0);
         chk({tag, "_hold"}, ifc8.diff, prev);
         tick();
      end
      chk({tag, "_done"}, ifc8.done, 1);
      chk({tag, "_idle"}, ifc8.busy, 0);
      chk({tag, "_diff"}, ifc8.diff, ed);
      chk({tag, "_borrow"}, ifc8.borrow, eb);
   endtask

   initial begin
      ifc8.start = 1'b0; ifc8.a = '0; ifc8.b = '0;
      ifc2.start = 1'b0; ifc2.a = '0; ifc2.b = '0;
      rst = 1'b1;
      tick(); tick();
      chk("rst_busy", ifc8.busy, 0);
      chk("rst_done", ifc8.done, 0);
      chk("rst_diff", ifc8.diff, 0);
      chk("rst_borrow", ifc8.borrow, 0);
`ifdef BIT_SERIAL_SUB_OVF_EN
      chk("rst_ovf", ifc8.ovf, 0);
`endif
      rst = 1'b0;
      tick();

      run8(8'h5A, 8'h23, 8'h00, 8'h37, 1'b0, "t5a23");
      tick();
      chk("t5a23_pulse", ifc8.done, 0);
      run8(8'h10, 8'h20, 8'h37, 8'hF0, 1'b1, "t1020");
      tick();
      run8(8'h00, 8'h00, 8'hF0, 8'h00, 1'b0, "t0000");
      tick();
      run8(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, "tffff");
      tick();

      // start while busy is ignored; start in the done cycle is taken
      ifc8.a = 8'h05; ifc8.b = 8'h03; ifc8.start = 1'b1;
      tick();
      ifc8.start = 1'b0;
      tick();
      ifc8.a = 8'h99; ifc8.b = 8'h11; ifc8.start = 1'b1;
      tick();
      ifc8.start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("ign_done", ifc8.done, 1);
      chk("ign_diff", ifc8.diff, 8'h02);
      chk("ign_borrow", ifc8.borrow, 0);
      run8(8'h99, 8'h11, 8'h02, 8'h88, 1'b0, "b2b");
      tick();

      // reset in the middle of a run aborts it
      ifc8.a = 8'h40; ifc8.b = 8'h01; ifc8.start = 1'b1;
      tick();
      ifc8.start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", ifc8.busy, 0);
      chk("abort_done", ifc8.done, 0);
      chk("abort_diff", ifc8.diff, 0);
      chk("abort_borrow", ifc8.borrow, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("abort_nopulse", ifc8.done, 0);
      end

`ifdef BIT_SERIAL_SUB_OVF_EN
      run8(8'h80, 8'h01, 8'h00, 8'h7F, 1'b0, "ov8001");
      chk("ov8001_ovf", ifc8.ovf, 1);
      tick();
      run8(8'h7F, 8'hFF, 8'h7F, 8'h80, 1'b1, "ov7fff");
      chk("ov7fff_ovf", ifc8.ovf, 1);
      tick();
      run8(8'h05, 8'h03, 8'h80, 8'h02, 1'b0, "ov0503");
      chk("ov0503_ovf", ifc8.ovf, 0);
      tick();
`endif

      // WIDTH=2 exhaustive, each new start issued in the previous done cycle
      for (int p = 0; p < 16; p++) begin
         logic [1:0] va, vb, ed;
         va = 2'(p >> 2);
         vb = 2'(p);
         ed = va - vb;
         ifc2.a = va; ifc2.b = vb; ifc2.start = 1'b1;
         tick();
         ifc2.start = 1'b0;
         chk("w2_busy", ifc2.busy, 1);
         tick();
         chk("w2_nodone", ifc2.done, 0);
         tick();
         chk("w2_done", ifc2.done, 1);
         chk("w2_diff", ifc2.diff, ed);
         chk("w2_borrow", ifc2.borrow, (va < vb) ? 1 : 0);
      end
      tick();
      chk("w2_pulse_end", ifc2.done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
